// File: rtl/ctr_enabler_pkg.sv
// Shared definitions for the processing-window controller: channel state
// encoding and the lane-offset helper used to slice packed per-channel buses.
package ctr_enabler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PROC = 1'b1
  } ch_state_e;

  // LSB position of channel ch inside a bus packed as NUM_CH lanes of lane_w bits.
  function automatic int lane_lsb(input int ch, input int lane_w);
    return ch * lane_w;
  endfunction

endpackage

// File: rtl/ctr_enabler_ch.sv
// One processing-window channel: opens on init, closes on external done or
// after len enabled cycles (when AUTO_STOP), reporting count/done/timeout.
module ctr_enabler_ch
  import ctr_enabler_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit AUTO_STOP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srst,
  input  logic             en,
  input  logic             ch_en,
  input  logic             init,
  input  logic             done,
  input  logic [CNT_W-1:0] len,
  output logic             proc_en,
  output logic             module_en,
  output logic [CNT_W-1:0] cnt,
  output logic             done_pulse,
  output logic             timeout
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             terminal;

  assign proc_en    = (state_q == ST_PROC);
  assign module_en  = proc_en & en & ch_en;
  assign cnt        = cnt_q;
  assign done_pulse = done_q;
  assign timeout    = timeout_q;

  // Saturating increment keeps an unlimited (len = 0) window from wrapping.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign terminal = AUTO_STOP && (len_q != '0) && module_en &&
                    (cnt_q == len_q - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;

    if (srst) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      len_d     = '0;
      timeout_d = 1'b0;
    end else if (init) begin
      state_d   = ST_PROC;
      cnt_d     = '0;
      len_d     = len;
      timeout_d = 1'b0;
    end else if (state_q == ST_PROC) begin
      // External done outranks the terminal count, so it never flags a timeout.
      if (done) begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        timeout_d = 1'b0;
        cnt_d     = module_en ? cnt_inc : cnt_q;
      end else if (terminal) begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        timeout_d = 1'b1;
        cnt_d     = len_q;
      end else if (module_en) begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: rtl/ctr_enabler_mc.sv
// Multi-channel processing-window controller: NUM_CH independent channels
// plus an OR of all open windows.
module ctr_enabler_mc
  import ctr_enabler_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter bit AUTO_STOP = 1'b1
) (
  input  logic                    clk,
  input  logic                    in_Arst,
  input  logic                    in_Srst,
  input  logic                    in_en,
  input  logic [NUM_CH-1:0]       in_ch_en,
  input  logic [NUM_CH-1:0]       in_init,
  input  logic [NUM_CH-1:0]       in_done,
  input  logic [NUM_CH*CNT_W-1:0] in_len,
  output logic [NUM_CH-1:0]       out_module_proc_en,
  output logic [NUM_CH-1:0]       out_module_en,
  output logic [NUM_CH*CNT_W-1:0] out_cnt,
  output logic [NUM_CH-1:0]       out_done,
  output logic [NUM_CH-1:0]       out_timeout,
  output logic                    out_any_proc_en
);

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    localparam int LSB = lane_lsb(i, CNT_W);

    ctr_enabler_ch #(
      .CNT_W     (CNT_W),
      .AUTO_STOP (AUTO_STOP)
    ) u_ch (
      .clk        (clk),
      .rst        (in_Arst),
      .srst       (in_Srst),
      .en         (in_en),
      .ch_en      (in_ch_en[i]),
      .init       (in_init[i]),
      .done       (in_done[i]),
      .len        (in_len[LSB +: CNT_W]),
      .proc_en    (out_module_proc_en[i]),
      .module_en  (out_module_en[i]),
      .cnt        (out_cnt[LSB +: CNT_W]),
      .done_pulse (out_done[i]),
      .timeout    (out_timeout[i])
    );
  end

  assign out_any_proc_en = |out_module_proc_en;

endmodule

// File: tb/tb_ctr_enabler_mc.sv
// Self-checking bench for ctr_enabler_mc: directed scenarios plus random traffic
// against a window-level reference model, and a narrow non-auto-stop instance.
module tb_ctr_enabler_mc;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              in_Arst, in_Srst, in_en;
  logic [NCH-1:0]    in_ch_en, in_init, in_done;
  logic [NCH*CW-1:0] in_len;
  logic [NCH-1:0]    dut_proc, dut_men, dut_done, dut_to;
  logic [NCH*CW-1:0] dut_cnt;
  logic              dut_any;

  logic       s_srst, s_en;
  logic [0:0] s_ch_en, s_init, s_done;
  logic [3:0] s_len;
  logic [0:0] s_proc, s_men, s_dn, s_to;
  logic [3:0] s_cnt;
  logic       s_any;

  ctr_enabler_mc #(.NUM_CH(NCH), .CNT_W(CW), .AUTO_STOP(1'b1)) dut (
    .clk                (clk),
    .in_Arst            (in_Arst),
    .in_Srst            (in_Srst),
    .in_en              (in_en),
    .in_ch_en           (in_ch_en),
    .in_init            (in_init),
    .in_done            (in_done),
    .in_len             (in_len),
    .out_module_proc_en (dut_proc),
    .out_module_en      (dut_men),
    .out_cnt            (dut_cnt),
    .out_done           (dut_done),
    .out_timeout        (dut_to),
    .out_any_proc_en    (dut_any)
  );

  ctr_enabler_mc #(.NUM_CH(1), .CNT_W(4), .AUTO_STOP(1'b0)) dut_sat (
    .clk                (clk),
    .in_Arst            (in_Arst),
    .in_Srst            (s_srst),
    .in_en              (s_en),
    .in_ch_en           (s_ch_en),
    .in_init            (s_init),
    .in_done            (s_done),
    .in_len             (s_len),
    .out_module_proc_en (s_proc),
    .out_module_en      (s_men),
    .out_cnt            (s_cnt),
    .out_done           (s_dn),
    .out_timeout        (s_to),
    .out_any_proc_en    (s_any)
  );

  int n_vec = 0;
  int n_err = 0;

  // Window-level model: is the window open, how many enabled cycles used, its length.
  bit m_open [NCH];
  int m_cnt  [NCH];
  int m_len  [NCH];
  bit m_to   [NCH];
  bit m_done [NCH];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      m_open[i] = 0; m_cnt[i] = 0; m_len[i] = 0; m_to[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < NCH; i++) begin
      bit used;
      int next;
      used = m_open[i] && in_en && in_ch_en[i];
      next = used ? ((m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1) : m_cnt[i];
      m_done[i] = 0;
      if (in_Srst) begin
        m_open[i] = 0; m_cnt[i] = 0; m_len[i] = 0; m_to[i] = 0;
      end else if (in_init[i]) begin
        m_open[i] = 1; m_cnt[i] = 0; m_len[i] = int'(in_len[i*CW +: CW]); m_to[i] = 0;
      end else if (m_open[i]) begin
        if (in_done[i]) begin
          m_open[i] = 0; m_done[i] = 1; m_cnt[i] = next;
        end else if (m_len[i] > 0 && used && next == m_len[i]) begin
          m_open[i] = 0; m_done[i] = 1; m_to[i] = 1; m_cnt[i] = m_len[i];
        end else begin
          m_cnt[i] = next;
        end
      end
    end
  endtask

  task automatic checkOutput();
    bit any;
    any = 0;
    for (int i = 0; i < NCH; i++) begin
      cmp($sformatf("ch%0d proc_en", i), 32'(dut_proc[i]), 32'(m_open[i]));
      cmp($sformatf("ch%0d cnt", i), 32'(dut_cnt[i*CW +: CW]), m_cnt[i]);
      cmp($sformatf("ch%0d done", i), 32'(dut_done[i]), 32'(m_done[i]));
      cmp($sformatf("ch%0d timeout", i), 32'(dut_to[i]), 32'(m_to[i]));
      any |= m_open[i];
    end
    cmp("any_proc_en", 32'(dut_any), 32'(any));
  endtask

  task automatic checkComb();
    for (int i = 0; i < NCH; i++)
      cmp($sformatf("ch%0d module_en", i), 32'(dut_men[i]),
          32'(m_open[i] && in_en && in_ch_en[i]));
  endtask

  // Called just after an edge with the next inputs already driven.
  task automatic applyStimulus();
    #1;
    checkComb();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic setLen(input int ch, input int v);
    in_len[ch*CW +: CW] = CW'(v);
  endtask

  initial begin
    in_Arst = 1'b1; in_Srst = 1'b0; in_en = 1'b1; in_ch_en = '1;
    in_init = '0; in_done = '0; in_len = '0;
    s_srst = 1'b0; s_en = 1'b1; s_ch_en = 1'b1; s_init = 1'b0; s_done = 1'b0; s_len = '0;
    modelReset();
    #2;
    checkOutput();
    cmp("sat reset cnt", 32'(s_cnt), 0);
    @(posedge clk); #1;
    in_Arst = 1'b0;
    checkOutput();

    // Length stop on ch0
    setLen(0, 5); in_init = 4'b0001; applyStimulus();
    in_init = '0;
    repeat (5) applyStimulus();
    cmp("lenstop cnt", 32'(dut_cnt[0 +: CW]), 5);
    cmp("lenstop done", 32'(dut_done[0]), 1);
    cmp("lenstop timeout", 32'(dut_to[0]), 1);
    repeat (2) applyStimulus();

    // Stall on ch1
    setLen(1, 4); in_init = 4'b0010; applyStimulus();
    in_init = '0; applyStimulus();
    in_en = 1'b0; repeat (3) applyStimulus();
    in_en = 1'b1; repeat (3) applyStimulus();
    cmp("stall cnt", 32'(dut_cnt[CW +: CW]), 4);
    cmp("stall done", 32'(dut_done[1]), 1);
    applyStimulus();

    // External done on ch2 with unlimited length
    setLen(2, 0); in_init = 4'b0100; applyStimulus();
    in_init = '0; repeat (9) applyStimulus();
    in_done = 4'b0100; applyStimulus();
    cmp("extdone cnt", 32'(dut_cnt[2*CW +: CW]), 10);
    cmp("extdone done", 32'(dut_done[2]), 1);
    cmp("extdone timeout", 32'(dut_to[2]), 0);
    in_done = '0; applyStimulus();
    in_done = 4'b0100; applyStimulus();
    cmp("idle done ignored", 32'(dut_done[2]), 0);
    in_done = '0; applyStimulus();

    // init + done together restarts the window
    setLen(3, 6); in_init = 4'b1000; applyStimulus();
    in_init = '0; repeat (2) applyStimulus();
    in_init = 4'b1000; in_done = 4'b1000; applyStimulus();
    cmp("init+done proc", 32'(dut_proc[3]), 1);
    cmp("init+done cnt", 32'(dut_cnt[3*CW +: CW]), 0);
    cmp("init+done no pulse", 32'(dut_done[3]), 0);
    in_init = '0; in_done = '0;

    // done coinciding with terminal count
    repeat (5) applyStimulus();
    in_done = 4'b1000; applyStimulus();
    cmp("done+term done", 32'(dut_done[3]), 1);
    cmp("done+term timeout", 32'(dut_to[3]), 0);
    cmp("done+term cnt", 32'(dut_cnt[3*CW +: CW]), 6);
    in_done = '0; applyStimulus();

    // Staggered starts
    setLen(0, 3); setLen(1, 5); setLen(2, 2); setLen(3, 7);
    in_init = 4'b0001; applyStimulus();
    in_init = 4'b0010; applyStimulus();
    in_init = 4'b0100; applyStimulus();
    in_init = 4'b1000; applyStimulus();
    in_init = '0; repeat (10) applyStimulus();

    // Async reset mid-window
    for (int i = 0; i < NCH; i++) setLen(i, 9);
    in_init = '1; applyStimulus();
    in_init = '0; repeat (3) applyStimulus();
    in_Arst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    checkComb();
    @(posedge clk); #1;
    in_Arst = 1'b0;
    applyStimulus();

    // Synchronous clear mid-window
    in_init = '1; applyStimulus();
    in_init = '0; repeat (2) applyStimulus();
    in_Srst = 1'b1; applyStimulus();
    in_Srst = 1'b0; applyStimulus();

    // Random traffic
    repeat (400) begin
      in_en    = ($urandom_range(0, 7) != 0);
      in_ch_en = 4'($urandom);
      for (int i = 0; i < NCH; i++) begin
        in_init[i] = ($urandom_range(0, 9) == 0);
        in_done[i] = ($urandom_range(0, 11) == 0);
        setLen(i, $urandom_range(0, 12));
      end
      in_Srst = ($urandom_range(0, 99) == 0);
      applyStimulus();
    end
    in_init = '0; in_done = '0; in_Srst = 1'b0; in_en = 1'b1; in_ch_en = '1;

    // Narrow counter, len = 0: saturates at 15
    s_len = 4'd0; s_init = 1'b1;
    @(posedge clk); #1;
    s_init = 1'b0;
    cmp("sat open", 32'(s_proc), 1);
    cmp("sat start cnt", 32'(s_cnt), 0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      cmp($sformatf("sat cnt k=%0d", k), 32'(s_cnt), (k > 15) ? 15 : k);
    end
    cmp("sat still open", 32'(s_any), 1);
    s_done = 1'b1;
    @(posedge clk); #1;
    s_done = 1'b0;
    cmp("sat close proc", 32'(s_proc), 0);
    cmp("sat close done", 32'(s_dn), 1);
    cmp("sat close cnt", 32'(s_cnt), 15);

    // Without auto-stop a nonzero length does not close the window
    s_len = 4'd3; s_init = 1'b1;
    @(posedge clk); #1;
    s_init = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    cmp("noauto open", 32'(s_proc), 1);
    cmp("noauto module_en", 32'(s_men), 1);
    cmp("noauto cnt", 32'(s_cnt), 6);
    cmp("noauto done", 32'(s_dn), 0);
    s_done = 1'b1;
    @(posedge clk); #1;
    s_done = 1'b0;
    cmp("noauto close done", 32'(s_dn), 1);
    cmp("noauto timeout", 32'(s_to), 0);
    s_srst = 1'b1;
    @(posedge clk); #1;
    s_srst = 1'b0;
    cmp("sat srst cnt", 32'(s_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctr_enabler_mc.md
Name: ctr_enabler_mc

Overview:
Multi-channel, parametrised processing-window controller for the decoder's time-control layer. Each of NUM_CH channels opens a processing window on an init pulse. The window closes on an external done pulse or after a programmed number of enabled cycles. Per-channel gated enables, cycle counts, done pulses and timeout flags drive the syndrome/key-equation/Chien stages without extra glue logic.

Parameters:
NUM_CH, 4, number of independent channels
CNT_W, 8, width of per-channel length and cycle counter
AUTO_STOP, 1, 1 = window closes when the count reaches the programmed length; 0 = only in_done closes it

Ports:
clk  input  1  system clock, rising edge
in_Arst  input  1  asynchronous active-high reset
in_Srst  input  1  synchronous clear, all channels
in_en  input  1  global enable (stall when low)
in_ch_en  input  NUM_CH  per-channel enable
in_init  input  NUM_CH  per-channel start pulse
in_done  input  NUM_CH  per-channel external stop pulse
in_len  input  NUM_CH*CNT_W  per-channel window length, channel i at [i*CNT_W +: CNT_W]; sampled on init
out_module_proc_en  output  NUM_CH  window open (registered)
out_module_en  output  NUM_CH  proc_en & in_en & in_ch_en (combinational)
out_cnt  output  NUM_CH*CNT_W  enabled cycles consumed in the current or last window
out_done  output  NUM_CH  one-cycle pulse after a window closes
out_timeout  output  NUM_CH  sticky: last window closed by length, not by in_done
out_any_proc_en  output  1  OR of out_module_proc_en

Behaviour:
- Async reset: every register is 0. All outputs are 0, including out_cnt and out_timeout. in_Srst gives the same result on the next edge.
- Priority per channel, per edge: in_Arst > in_Srst > in_init > in_done > terminal count.
- Channel state machine: IDLE and PROC. The state is out_module_proc_en.
- IDLE -> PROC when in_init=1:
  - The cycle after the init edge: proc_en=1, cnt=0, len_r=in_len, timeout=0.
- PROC, in_init=1: restart. cnt=0, len_r reloaded, timeout=0, no done pulse.
- PROC, in_done=1, in_init=0:
  - Next cycle: proc_en=0 and out_done=1 for one cycle.
  - timeout stays 0.
  - cnt still increments if module_en was 1 that cycle.
- Counting: cnt increments by 1 on each edge where out_module_en=1. If in_en=0 or in_ch_en=0, cnt holds and proc_en stays 1 (stall).
- Terminal count, only when AUTO_STOP=1 and len_r != 0:
  - Trigger: module_en=1 and cnt == len_r-1, with no init or done.
  - Next cycle: cnt=len_r, proc_en=0, out_done=1 for one cycle, timeout=1.
  - Result: exactly len_r enabled cycles per window.
- len_r = 0: unlimited window; only in_done closes it. cnt saturates at all-ones with no wrap.
- IDLE behaviour:
  - in_done is ignored: no pulse.
  - cnt and timeout hold their last values until the next init or reset.
- Simultaneous init and done: init wins, no done pulse.
- Simultaneous done and terminal count: treated as done, timeout=0.
- Reset mid-window: window aborted, no done pulse.
- Latency:
  - init -> proc_en: 1 cycle.
  - Closing edge -> proc_en low, and out_done high in that same cycle.
  - module_en follows in_en and in_ch_en combinationally.
- Channels are fully independent. No shared state except out_any_proc_en.

Decomposition:
- Package ctr_enabler_pkg: state encodings ST_IDLE=0 and ST_PROC=1, and a helper for slicing the CNT_W lane.
- Sub-module ctr_enabler_ch: one channel with scalar ports plus AUTO_STOP and CNT_W parameters.
  - The top instantiates NUM_CH copies in a generate loop and builds the OR reduction.

Test Plan:
- Length stop: ch0, AUTO_STOP=1, in_len=5, in_en=in_ch_en=1, init pulse -> proc_en high for 5 cycles; out_cnt 0..5; out_done pulse on the cycle proc_en falls; out_timeout=1.
- Stall: ch1, len=4, in_en low for 3 cycles mid-window -> proc_en high for 7 cycles, module_en high for exactly 4; final cnt=4.
- External done: ch2, len=0, in_done pulse after 10 enabled cycles -> cnt=10 if module_en was high on the done cycle; out_done pulse; timeout=0; a later in_done in IDLE gives no pulse.
- Conflicts:
  - init and done together in PROC -> restart, cnt=0, no out_done.
  - done and terminal together -> out_done=1, timeout=0.
- Reset: in_Arst asserted mid-window on all channels -> all outputs 0 immediately, no done pulse. Repeat with in_Srst -> all outputs 0 after the next edge.
- Independence/saturation:
  - Four channels started on staggered cycles -> each has a correct count and closing cycle; out_any_proc_en is their OR.
  - CNT_W=4, len=0, 20 cycles -> cnt saturates at 15.
